// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
package seg7_pkg;

  localparam int DIGIT_W    = 4;
  localparam int VALUE_W    = 16;
  localparam int HOLD_500MS = 50000000;

  // Arbiter FSM states: waiting for a request, or dwelling on a grant.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_display_arbiter_rr_pick.sv
// Combinational round-robin selector. The request vector is doubled and
// every bit below ptr is masked. The lowest remaining set bit is the first
// requester at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         winner,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [2*NUM_REQ-1:0] mask_s;
  logic [2*NUM_REQ-1:0] masked_s;
  logic                 found_s;

  // Masked priority encode over the doubled request vector.
  always_comb begin
    dbl_s    = {req, req};
    mask_s   = '0;
    winner   = 3'd0;
    found_s  = 1'b0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      mask_s[i] = (i >= int'(ptr));
    end
    masked_s = dbl_s & mask_s;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (masked_s[i] && !found_s) begin
        found_s = 1'b1;
        winner  = (i >= NUM_REQ) ? 3'(i - NUM_REQ) : 3'(i);
      end else begin
        found_s = found_s;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Shares one 4-digit seven-segment display between NUM_REQ requesters.
// Grants are round-robin; each winner's value is snapshotted and held on
// the display for HOLD_CYCLES cycles before the next arbitration.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = HOLD_500MS,
  parameter int HOLD_WIDTH  = 26
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic [VALUE_W*NUM_REQ-1:0] VALUE,
  output logic [NUM_REQ-1:0]         GRANT,
  output logic [2:0]                 OWNER,
  output logic                       BUSY,
  output logic [DIGIT_W-1:0]         NUM0,
  output logic [DIGIT_W-1:0]         NUM1,
  output logic [DIGIT_W-1:0]         NUM2,
  output logic [DIGIT_W-1:0]         NUM3
);

  state_t                state_r, state_n;
  logic [HOLD_WIDTH-1:0] cnt_r, cnt_n;
  logic [2:0]            ptr_r, ptr_n;
  logic [2:0]            owner_r, owner_n;
  logic [NUM_REQ-1:0]    grant_r, grant_n;
  logic                  busy_r, busy_n;
  logic [VALUE_W-1:0]    value_r, value_n;

  logic [2:0]            pick_winner_s;
  logic                  pick_valid_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (REQ),
    .ptr    (ptr_r),
    .winner (pick_winner_s),
    .valid  (pick_valid_s)
  );

  // Next-state and next-output logic for the IDLE/HOLD arbiter.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    ptr_n   = ptr_r;
    owner_n = owner_r;
    grant_n = '0;
    busy_n  = busy_r;
    value_n = value_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_n[i] = (pick_winner_s == 3'(i));
            value_n    = (pick_winner_s == 3'(i)) ? VALUE[i*VALUE_W +: VALUE_W] : value_n;
          end
          owner_n = pick_winner_s;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (cnt_r == HOLD_WIDTH'(HOLD_CYCLES - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
          ptr_n   = (owner_r == 3'(NUM_REQ - 1)) ? 3'd0 : owner_r + 3'd1;
        end else begin
          cnt_n   = cnt_r + HOLD_WIDTH'(1);
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  // State, dwell counter, pointer and output registers; reset clears the display.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      ptr_r   <= 3'd0;
      owner_r <= 3'd0;
      grant_r <= '0;
      busy_r  <= 1'b0;
      value_r <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      grant_r <= grant_n;
      busy_r  <= busy_n;
      value_r <= value_n;
    end
  end

  assign GRANT = grant_r;
  assign OWNER = owner_r;
  assign BUSY  = busy_r;
  assign NUM0  = value_r[3:0];
  assign NUM1  = value_r[7:4];
  assign NUM2  = value_r[11:8];
  assign NUM3  = value_r[15:12];

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed testbench for seg7_display_arbiter with NUM_REQ=3, HOLD_CYCLES=4.
module tb_seg7_display_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] v0, v1, v2;
  logic [47:0] value_bus;
  logic [2:0]  grant;
  logic [2:0]  owner;
  logic        busy;
  logic [3:0]  num0, num1, num2, num3;
  logic [15:0] disp;

  int checks = 0;
  int errors = 0;

  assign value_bus = {v2, v1, v0};
  assign disp      = {num3, num2, num1, num0};

  seg7_display_arbiter #(
    .NUM_REQ     (3),
    .HOLD_CYCLES (4),
    .HOLD_WIDTH  (3)
  ) dut (
    .CLK   (clk),
    .RESET (reset),
    .REQ   (req),
    .VALUE (value_bus),
    .GRANT (grant),
    .OWNER (owner),
    .BUSY  (busy),
    .NUM0  (num0),
    .NUM1  (num1),
    .NUM2  (num2),
    .NUM3  (num3)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0 || owner !== 3'd0 || disp !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: grant=%b busy=%b owner=%0d disp=%h expected 000 0 0 0000",
               grant, busy, owner, disp);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0 || disp !== 16'h0000) begin
        errors++;
        $display("FAIL idle_cycle%0d: grant=%b busy=%b disp=%h expected 000 0 0000",
                 c, grant, busy, disp);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    v1  = 16'h12AB;
    req = 3'b010;
    tick();
    checks++;
    if (grant !== 3'b010 || owner !== 3'd1 || busy !== 1'b1 || disp !== 16'h12AB) begin
      errors++;
      $display("FAIL single_grant: grant=%b owner=%0d busy=%b disp=%h expected 010 1 1 12ab",
               grant, owner, busy, disp);
    end
    req = 3'b000;
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if (grant !== 3'b000 || busy !== 1'b1 || disp !== 16'h12AB) begin
        errors++;
        $display("FAIL single_hold%0d: grant=%b busy=%b disp=%h expected 000 1 12ab",
                 c, grant, busy, disp);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 3'b000 || disp !== 16'h12AB) begin
      errors++;
      $display("FAIL single_release: busy=%b grant=%b disp=%h expected 0 000 12ab",
               busy, grant, disp);
    end
  endtask

  task automatic test_fairness();
    logic [2:0]  exp_grant [4];
    logic [15:0] exp_disp  [4];
    exp_grant[0] = 3'b001; exp_disp[0] = 16'h000A;
    exp_grant[1] = 3'b010; exp_disp[1] = 16'h000B;
    exp_grant[2] = 3'b100; exp_disp[2] = 16'h000C;
    exp_grant[3] = 3'b001; exp_disp[3] = 16'h000A;
    do_reset();
    v0  = 16'h000A;
    v1  = 16'h000B;
    v2  = 16'h000C;
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      tick();
      checks++;
      if (grant !== exp_grant[g] || busy !== 1'b1 || disp !== exp_disp[g] || owner !== 3'(g % 3)) begin
        errors++;
        $display("FAIL rr_grant%0d: grant=%b owner=%0d busy=%b disp=%h expected %b %0d 1 %h",
                 g, grant, owner, busy, disp, exp_grant[g], g % 3, exp_disp[g]);
      end
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (busy !== 1'b1 || grant !== 3'b000) begin
        errors++;
        $display("FAIL rr_hold_end%0d: busy=%b grant=%b expected 1 000", g, busy, grant);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || grant !== 3'b000) begin
        errors++;
        $display("FAIL rr_idle_gap%0d: busy=%b grant=%b expected 0 000", g, busy, grant);
      end
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_snapshot_and_wrap();
    do_reset();
    v2  = 16'h0042;
    req = 3'b100;
    tick();
    checks++;
    if (grant !== 3'b100 || owner !== 3'd2 || disp !== 16'h0042) begin
      errors++;
      $display("FAIL snap_grant: grant=%b owner=%0d disp=%h expected 100 2 0042", grant, owner, disp);
    end
    v2  = 16'h0099;
    req = 3'b000;
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || disp !== 16'h0042) begin
        errors++;
        $display("FAIL snap_hold%0d: busy=%b disp=%h expected 1 0042", c, busy, disp);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || disp !== 16'h0042) begin
      errors++;
      $display("FAIL snap_release: busy=%b disp=%h expected 0 0042", busy, disp);
    end
    // Pointer now past requester 2, so 0 wins over 2.
    v0  = 16'h0123;
    req = 3'b101;
    tick();
    checks++;
    if (grant !== 3'b001 || owner !== 3'd0 || disp !== 16'h0123) begin
      errors++;
      $display("FAIL wrap_grant: grant=%b owner=%0d disp=%h expected 001 0 0123", grant, owner, disp);
    end
    for (int c = 0; c < 4; c++) tick();
    tick();
    checks++;
    if (grant !== 3'b100 || owner !== 3'd2 || disp !== 16'h0099) begin
      errors++;
      $display("FAIL wrap_next: grant=%b owner=%0d disp=%h expected 100 2 0099", grant, owner, disp);
    end
    req = 3'b000;
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    v1  = 16'h5555;
    v2  = 16'h0042;
    req = 3'b100;
    tick();
    req = 3'b000;
    tick();
    checks++;
    if (busy !== 1'b1 || owner !== 3'd2) begin
      errors++;
      $display("FAIL midhold_setup: busy=%b owner=%0d expected 1 2", busy, owner);
    end
    reset = 1'b1;
    req   = 3'b110;
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 3'b000 || owner !== 3'd0 || disp !== 16'h0000) begin
      errors++;
      $display("FAIL midhold_reset: busy=%b grant=%b owner=%0d disp=%h expected 0 000 0 0000",
               busy, grant, owner, disp);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 3'b010 || owner !== 3'd1 || busy !== 1'b1 || disp !== 16'h5555) begin
      errors++;
      $display("FAIL midhold_regrant: grant=%b owner=%0d busy=%b disp=%h expected 010 1 1 5555",
               grant, owner, busy, disp);
    end
    req = 3'b000;
    for (int c = 0; c < 5; c++) tick();
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    v0    = 16'h0000;
    v1    = 16'h0000;
    v2    = 16'h0000;
    test_reset();
    test_single();
    test_fairness();
    test_snapshot_and_wrap();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
